// File: rtl/sprite_path_mover_if.sv
// sprite_path_mover_if: move request, drawer handshake, segment-table load port
// and position/status outputs of sprite_path_mover.
// Teleport endpoints exist only when SPRITE_TELEPORT_EN is defined.
interface sprite_path_mover_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int NUM_SEG = 8
);
  localparam int AW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

  logic                move;
  logic [1:0]          dir;
  logic                done_bg;
  logic                done_char;
  logic                seg_we;
  logic [AW-1:0]       seg_addr;
  logic                seg_en;
  logic                seg_orient;
  logic signed [X_W:0] seg_k;
  logic [X_W-1:0]      seg_xmin;
  logic [X_W-1:0]      seg_xmax;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic                draw_bg;
  logic                draw_char;
  logic                busy;
  logic                blocked;
`ifdef SPRITE_TELEPORT_EN
  logic [X_W-1:0]      tp_src_x;
  logic [Y_W-1:0]      tp_src_y;
  logic [X_W-1:0]      tp_dst_x;
  logic [Y_W-1:0]      tp_dst_y;
`endif

  modport master (
`ifdef SPRITE_TELEPORT_EN
    output tp_src_x, tp_src_y, tp_dst_x, tp_dst_y,
`endif
    output move, dir, done_bg, done_char,
    output seg_we, seg_addr, seg_en, seg_orient, seg_k, seg_xmin, seg_xmax,
    input  x, y, draw_bg, draw_char, busy, blocked
  );

  modport slave (
`ifdef SPRITE_TELEPORT_EN
    input  tp_src_x, tp_src_y, tp_dst_x, tp_dst_y,
`endif
    input  move, dir, done_bg, done_char,
    input  seg_we, seg_addr, seg_en, seg_orient, seg_k, seg_xmin, seg_xmax,
    output x, y, draw_bg, draw_char, busy, blocked
  );
endinterface

// File: rtl/sprite_path_mover.sv
// sprite_path_mover: steps one sprite diagonally along a loadable table of
// 45-degree path segments, one move per divider tick, and sequences the
// erase/redraw requests to the sprite drawer.
// Optional feature macro: SPRITE_TELEPORT_EN (teleport source -> destination).
module sprite_path_mover #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int X_MAX    = 319,
  parameter int Y_MAX    = 239,
  parameter int NUM_SEG  = 8,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 6250000,
  parameter int START_X  = 95,
  parameter int START_Y  = 221
) (
  input logic               clock,
  input logic               resetn,
  sprite_path_mover_if.slave bus
);
  localparam int CW = X_W + 2;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic signed [CW-1:0] STEP_S = CW'(STEP);
  localparam logic signed [CW-1:0] XMAX_S = CW'(X_MAX);
  localparam logic signed [CW-1:0] YMAX_S = CW'(Y_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CHECK     = 3'd1;
  localparam logic [2:0] S_ERASE     = 3'd2;
  localparam logic [2:0] S_WAIT_BG   = 3'd3;
  localparam logic [2:0] S_UPDATE    = 3'd4;
  localparam logic [2:0] S_DRAW      = 3'd5;
  localparam logic [2:0] S_WAIT_CHAR = 3'd6;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 accept;
  logic [X_W-1:0]       pos_x;
  logic [Y_W-1:0]       pos_y;
  logic signed [CW-1:0] nxt_x, nxt_y;
  logic signed [CW-1:0] cand_x, cand_y;
  logic [X_W-1:0]       upd_x;
  logic [Y_W-1:0]       upd_y;
  logic                 in_range, on_path, valid;

  logic [NUM_SEG-1:0]   tab_en;
  logic [NUM_SEG-1:0]   tab_orient;
  logic signed [X_W:0]  tab_k    [NUM_SEG];
  logic [X_W-1:0]       tab_xmin [NUM_SEG];
  logic [X_W-1:0]       tab_xmax [NUM_SEG];

  // One axis of a diagonal move: +STEP or -STEP at the widened signed width.
  function automatic logic signed [CW-1:0] step_axis(input logic signed [CW-1:0] p,
                                                     input logic neg);
    return neg ? (p - STEP_S) : (p + STEP_S);
  endfunction

  // Candidate lies on the visible screen.
  function automatic logic coord_ok(input logic signed [CW-1:0] cx,
                                    input logic signed [CW-1:0] cy);
    return (cx >= 0) && (cx <= XMAX_S) && (cy >= 0) && (cy <= YMAX_S);
  endfunction

  // Candidate lies on one segment: inside [xmin,xmax] and on its diagonal line.
  function automatic logic seg_hit(input logic en, input logic orient,
                                   input logic signed [X_W:0] k,
                                   input logic [X_W-1:0] xmin,
                                   input logic [X_W-1:0] xmax,
                                   input logic signed [CW-1:0] cx,
                                   input logic signed [CW-1:0] cy);
    logic signed [CW-1:0] kk;
    logic signed [CW-1:0] line_y;
    kk     = CW'(k);
    line_y = orient ? (kk - cx) : (cx + kk);
    return en && (cx >= $signed(CW'(xmin))) && (cx <= $signed(CW'(xmax))) &&
           (cy == line_y);
  endfunction

  assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign accept = (state == S_IDLE) && bus.move && tick;

  // dir bit0 selects x decrement, bit1 selects y decrement
  assign nxt_x = step_axis($signed(CW'(pos_x)), bus.dir[0]);
  assign nxt_y = step_axis($signed(CW'(pos_y)), bus.dir[1]);

  // Any enabled slot containing the latched candidate makes it walkable.
  always_comb begin
    on_path = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      on_path = on_path | seg_hit(tab_en[i], tab_orient[i], tab_k[i],
                                  tab_xmin[i], tab_xmax[i], cand_x, cand_y);
    end
  end

  assign in_range = coord_ok(cand_x, cand_y);

`ifdef SPRITE_TELEPORT_EN
  logic tp_hit;
  logic tp_flag;

  assign tp_hit = (cand_x == $signed(CW'(bus.tp_src_x))) &&
                  (cand_y == $signed(CW'(bus.tp_src_y)));

  // Remember a teleport decision from CHECK until the position update consumes it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                tp_flag <= 1'b0;
    else if (state == S_CHECK)  tp_flag <= tp_hit;
    else if (state == S_UPDATE) tp_flag <= 1'b0;
  end

  assign valid = tp_hit || (in_range && on_path);
  assign upd_x = tp_flag ? bus.tp_dst_x : cand_x[X_W-1:0];
  assign upd_y = tp_flag ? bus.tp_dst_y : cand_y[Y_W-1:0];
`else
  assign valid = in_range && on_path;
  assign upd_x = cand_x[X_W-1:0];
  assign upd_y = cand_y[Y_W-1:0];
`endif

  // Free-running move-rate divider, keeps counting while the FSM is busy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)   tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // Candidate is captured once, when a tick-aligned move leaves IDLE.
  always_ff @(posedge clock) begin
    if (accept) begin
      cand_x <= nxt_x;
      cand_y <= nxt_y;
    end
  end

  // Enables are control state and clear on reset; slot geometry is plain data.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         tab_en <= '0;
    else if (bus.seg_we) tab_en[bus.seg_addr] <= bus.seg_en;
  end

  // Slot geometry load; visible to CHECK from the cycle after the write.
  always_ff @(posedge clock) begin
    if (bus.seg_we) begin
      tab_orient[bus.seg_addr] <= bus.seg_orient;
      tab_k[bus.seg_addr]      <= bus.seg_k;
      tab_xmin[bus.seg_addr]   <= bus.seg_xmin;
      tab_xmax[bus.seg_addr]   <= bus.seg_xmax;
    end
  end

  // Move sequencer; position changes only in UPDATE so erase uses the old spot.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      pos_x <= X_W'(START_X);
      pos_y <= Y_W'(START_Y);
    end else begin
      case (state)
        S_IDLE:      if (accept) state <= S_CHECK;
        S_CHECK:     state <= valid ? S_ERASE : S_IDLE;
        S_ERASE:     state <= S_WAIT_BG;
        S_WAIT_BG:   if (bus.done_bg) state <= S_UPDATE;
        S_UPDATE: begin
          state <= S_DRAW;
          pos_x <= upd_x;
          pos_y <= upd_y;
        end
        S_DRAW:      state <= S_WAIT_CHAR;
        S_WAIT_CHAR: if (bus.done_char) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  assign bus.x         = pos_x;
  assign bus.y         = pos_y;
  assign bus.draw_bg   = (state == S_ERASE) || (state == S_WAIT_BG);
  assign bus.draw_char = (state == S_DRAW)  || (state == S_WAIT_CHAR);
  assign bus.busy      = (state != S_IDLE);
  assign bus.blocked   = (state == S_CHECK) && !valid;
endmodule

// File: tb/tb_sprite_path_mover.sv
// tb_sprite_path_mover: directed scenarios for sprite_path_mover with a short
// tick divider; expected positions are worked out by hand from the path table.
module tb_sprite_path_mover;
  localparam int TICK_DIV = 4;

  logic clock = 1'b0;
  logic resetn;
  int   nvec = 0;
  int   nerr = 0;
  logic [8:0] cur_x;
  logic [7:0] cur_y;

  sprite_path_mover_if #(.X_W(9), .Y_W(8), .NUM_SEG(8)) bus ();

  sprite_path_mover #(.TICK_DIV(TICK_DIV)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic write_seg(input logic [2:0] a, input logic en, input logic orient,
                           input logic signed [9:0] k, input logic [8:0] xmin,
                           input logic [8:0] xmax);
    bus.seg_addr = a; bus.seg_en = en; bus.seg_orient = orient;
    bus.seg_k = k; bus.seg_xmin = xmin; bus.seg_xmax = xmax;
    bus.seg_we = 1'b1;
    cyc();
    bus.seg_we = 1'b0;
  endtask

  // One full move attempt from IDLE; dly = cycles from request to done.
  task automatic run_move(input logic [1:0] d, input int dly, input bit ok,
                          input bit hold, input bit spur,
                          input logic [8:0] ex, input logic [7:0] ey);
    int n;
    bus.move = 1'b1;
    bus.dir  = d;
    n = 0;
    while (bus.busy !== 1'b1 && n < TICK_DIV + 2) begin cyc(); n++; end
    nvec++;
    if (bus.busy !== 1'b1) begin
      nerr++; $display("FAIL accept: busy=%b after %0d cycles, required 1", bus.busy, n);
      bus.move = 1'b0; return;
    end
    if (!hold) bus.move = 1'b0;
    nvec++;
    if (bus.blocked !== !ok) begin
      nerr++; $display("FAIL check_blocked: blocked=%b required %b (dir %0d)", bus.blocked, !ok, d);
    end
    if (!ok) begin
      bus.move = 1'b0;
      cyc();
      nvec++;
      if ({bus.busy, bus.blocked, bus.draw_bg} !== 3'b000) begin
        nerr++; $display("FAIL blocked_idle: busy/blocked/draw_bg=%b required 000",
                         {bus.busy, bus.blocked, bus.draw_bg});
      end
      nvec++;
      if (bus.x !== cur_x || bus.y !== cur_y) begin
        nerr++; $display("FAIL blocked_pos: (%0d,%0d) required (%0d,%0d)", bus.x, bus.y, cur_x, cur_y);
      end
      return;
    end
    cyc();
    nvec++;
    if (bus.draw_bg !== 1'b1 || bus.x !== cur_x || bus.y !== cur_y) begin
      nerr++; $display("FAIL erase: draw_bg=%b pos=(%0d,%0d) required 1 (%0d,%0d)",
                       bus.draw_bg, bus.x, bus.y, cur_x, cur_y);
    end
    if (spur) begin bus.done_bg = 1'b1; bus.done_char = 1'b1; end
    cyc();
    bus.done_bg = 1'b0; bus.done_char = 1'b0;
    nvec++;
    if (bus.draw_bg !== 1'b1 || bus.draw_char !== 1'b0) begin
      nerr++; $display("FAIL wait_bg_entry: draw_bg=%b draw_char=%b required 1 0",
                       bus.draw_bg, bus.draw_char);
    end
    for (int i = 1; i < dly; i++) begin
      cyc();
      nvec++;
      if (bus.draw_bg !== 1'b1 || bus.x !== cur_x || bus.y !== cur_y) begin
        nerr++; $display("FAIL wait_bg: draw_bg=%b pos=(%0d,%0d) required 1 (%0d,%0d)",
                         bus.draw_bg, bus.x, bus.y, cur_x, cur_y);
      end
    end
    bus.done_bg = 1'b1;
    cyc();
    bus.done_bg = 1'b0;
    nvec++;
    if (bus.draw_bg !== 1'b0 || bus.draw_char !== 1'b0 || bus.busy !== 1'b1 ||
        bus.x !== cur_x || bus.y !== cur_y) begin
      nerr++; $display("FAIL update: bg=%b ch=%b busy=%b pos=(%0d,%0d) required 0 0 1 (%0d,%0d)",
                       bus.draw_bg, bus.draw_char, bus.busy, bus.x, bus.y, cur_x, cur_y);
    end
    cyc();
    nvec++;
    if (bus.draw_char !== 1'b1 || bus.x !== ex || bus.y !== ey) begin
      nerr++; $display("FAIL draw: draw_char=%b pos=(%0d,%0d) required 1 (%0d,%0d)",
                       bus.draw_char, bus.x, bus.y, ex, ey);
    end
    for (int i = 0; i < dly; i++) begin
      cyc();
      nvec++;
      if (bus.draw_char !== 1'b1 || bus.x !== ex || bus.y !== ey) begin
        nerr++; $display("FAIL wait_char: draw_char=%b pos=(%0d,%0d) required 1 (%0d,%0d)",
                         bus.draw_char, bus.x, bus.y, ex, ey);
      end
    end
    bus.done_char = 1'b1;
    cyc();
    bus.done_char = 1'b0;
    nvec++;
    if (bus.busy !== 1'b0 || bus.draw_char !== 1'b0 || bus.x !== ex || bus.y !== ey) begin
      nerr++; $display("FAIL done: busy=%b draw_char=%b pos=(%0d,%0d) required 0 0 (%0d,%0d)",
                       bus.busy, bus.draw_char, bus.x, bus.y, ex, ey);
    end
    cur_x = ex;
    cur_y = ey;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.move = 1'b0; bus.dir = 2'd0; bus.done_bg = 1'b0; bus.done_char = 1'b0;
    bus.seg_we = 1'b0; bus.seg_addr = '0; bus.seg_en = 1'b0; bus.seg_orient = 1'b0;
    bus.seg_k = '0; bus.seg_xmin = '0; bus.seg_xmax = '0;
`ifdef SPRITE_TELEPORT_EN
    bus.tp_src_x = '0; bus.tp_src_y = '0; bus.tp_dst_x = '0; bus.tp_dst_y = '0;
`endif
    cyc(); cyc();
    nvec++;
    if (bus.x !== 9'd95 || bus.y !== 8'd221) begin
      nerr++; $display("FAIL reset_pos: (%0d,%0d) required (95,221)", bus.x, bus.y);
    end
    nvec++;
    if ({bus.draw_bg, bus.draw_char, bus.busy, bus.blocked} !== 4'b0000) begin
      nerr++; $display("FAIL reset_ctl: bg/ch/busy/blk=%b required 0000",
                       {bus.draw_bg, bus.draw_char, bus.busy, bus.blocked});
    end
    @(negedge clock);
    resetn = 1'b1;
    cyc();
    cur_x = 9'd95;
    cur_y = 8'd221;
  endtask

  task automatic test_empty_table();
    int  nblk;
    int  n;
    bit  saw_bg;
    nblk = 0; n = 0; saw_bg = 1'b0;
    bus.move = 1'b1;
    bus.dir  = 2'd3;
    while (nblk < 3 && n < 20) begin
      cyc();
      n++;
      if (bus.blocked === 1'b1) nblk++;
      if (bus.draw_bg !== 1'b0) saw_bg = 1'b1;
      nvec++;
      if (bus.x !== 9'd95 || bus.y !== 8'd221) begin
        nerr++; $display("FAIL empty_pos: (%0d,%0d) required (95,221)", bus.x, bus.y);
      end
    end
    bus.move = 1'b0;
    cyc();
    nvec++;
    if (nblk != 3) begin
      nerr++; $display("FAIL empty_blocked: %0d pulses required 3", nblk);
    end
    nvec++;
    if (saw_bg) begin
      nerr++; $display("FAIL empty_draw_bg: draw_bg asserted, required never");
    end
  endtask

  task automatic test_first_step();
    write_seg(3'd0, 1'b1, 1'b1, 10'sd316, 9'd95, 9'd120);
    run_move(2'd2, 2, 1'b1, 1'b0, 1'b1, 9'd96, 8'd220);
  endtask

  task automatic test_walk_to_end();
    for (int i = 97; i <= 120; i++) run_move(2'd2, 1, 1'b1, 1'b0, 1'b0, 9'(i), 8'(316 - i));
    run_move(2'd2, 1, 1'b0, 1'b0, 1'b0, 9'd120, 8'd196);
  endtask

  task automatic test_write_in_check();
    int n;
    write_seg(3'd1, 1'b0, 1'b0, 10'sd76, 9'd100, 9'd130);
    bus.move = 1'b1;
    bus.dir  = 2'd0;
    n = 0;
    while (bus.busy !== 1'b1 && n < TICK_DIV + 2) begin cyc(); n++; end
    bus.move = 1'b0;
    bus.seg_addr = 3'd1; bus.seg_en = 1'b1; bus.seg_orient = 1'b0;
    bus.seg_k = 10'sd76; bus.seg_xmin = 9'd100; bus.seg_xmax = 9'd130;
    bus.seg_we = 1'b1;
    nvec++;
    if (bus.busy !== 1'b1 || bus.blocked !== 1'b1) begin
      nerr++; $display("FAIL write_in_check: busy=%b blocked=%b required 1 1", bus.busy, bus.blocked);
    end
    cyc();
    bus.seg_we = 1'b0;
    nvec++;
    if (bus.busy !== 1'b0 || bus.x !== 9'd120 || bus.y !== 8'd196) begin
      nerr++; $display("FAIL write_in_check_idle: busy=%b pos=(%0d,%0d) required 0 (120,196)",
                       bus.busy, bus.x, bus.y);
    end
  endtask

  task automatic test_orient0();
    run_move(2'd0, 1, 1'b1, 1'b0, 1'b0, 9'd121, 8'd197);
    run_move(2'd3, 1, 1'b1, 1'b0, 1'b0, 9'd120, 8'd196);
    run_move(2'd1, 2, 1'b1, 1'b0, 1'b0, 9'd119, 8'd197);
    run_move(2'd2, 1, 1'b1, 1'b0, 1'b0, 9'd120, 8'd196);
    write_seg(3'd1, 1'b0, 1'b0, 10'sd76, 9'd100, 9'd130);
    run_move(2'd0, 1, 1'b0, 1'b0, 1'b0, 9'd120, 8'd196);
  endtask

  task automatic test_hold_move();
    run_move(2'd1, 10, 1'b1, 1'b1, 1'b0, 9'd119, 8'd197);
    run_move(2'd1, 10, 1'b1, 1'b1, 1'b0, 9'd118, 8'd198);
    bus.move = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bus.move = 1'b1;
    bus.dir  = 2'd2;
    n = 0;
    while (bus.busy !== 1'b1 && n < TICK_DIV + 2) begin cyc(); n++; end
    bus.move = 1'b0;
    cyc();
    cyc();
    nvec++;
    if (bus.draw_bg !== 1'b1) begin
      nerr++; $display("FAIL pre_reset_wait_bg: draw_bg=%b required 1", bus.draw_bg);
    end
    #2;
    resetn = 1'b0;
    #1;
    nvec++;
    if (bus.draw_bg !== 1'b0 || bus.busy !== 1'b0) begin
      nerr++; $display("FAIL async_reset: draw_bg=%b busy=%b required 0 0", bus.draw_bg, bus.busy);
    end
    nvec++;
    if (bus.x !== 9'd95 || bus.y !== 8'd221) begin
      nerr++; $display("FAIL async_reset_pos: (%0d,%0d) required (95,221)", bus.x, bus.y);
    end
    @(negedge clock);
    resetn = 1'b1;
    cyc();
    cur_x = 9'd95;
    cur_y = 8'd221;
    run_move(2'd2, 1, 1'b0, 1'b0, 1'b0, 9'd95, 8'd221);
  endtask

  task automatic test_teleport();
`ifdef SPRITE_TELEPORT_EN
    bus.tp_src_x = 9'd96;  bus.tp_src_y = 8'd220;
    bus.tp_dst_x = 9'd126; bus.tp_dst_y = 8'd68;
    run_move(2'd2, 2, 1'b1, 1'b0, 1'b0, 9'd126, 8'd68);
    run_move(2'd2, 1, 1'b0, 1'b0, 1'b0, 9'd126, 8'd68);
`else
    run_move(2'd2, 1, 1'b0, 1'b0, 1'b0, 9'd95, 8'd221);
`endif
  endtask

  initial begin
    test_reset();
    test_empty_table();
    test_first_step();
    test_walk_to_end();
    test_write_in_check();
    test_orient0();
    test_hold_move();
    test_reset_mid_wait();
    test_teleport();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
